// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned FIFO_CNT_W = 8;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set request at or above start, wrapping to the bottom.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pool;

    always_comb begin
        // requests at or above start outrank those below it; fall back to the full set on wrap
        upper = req & ({NUM_REQ{1'b1}} << start);
        pool  = (upper != '0) ? upper : req;
        grant = pool & (~pool + NUM_REQ'(1));
        valid = (req != '0);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for up to BURST_LEN grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [FIFO_CNT_W-1:0]      fifo_counter,
    input  logic                       buf_full,
    output logic [DATA_W-1:0]          buf_in,
    output logic                       wr_en,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       overflow_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned BURST_LIMIT = BURST_LEN;
`else
    localparam int unsigned BURST_LIMIT = 1;
`endif
    localparam logic [FIFO_CNT_W:0] DEPTH_LIM = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

    arb_state_t         state, state_next;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_next;
    logic [IDX_W-1:0]   last_grant, start_idx, win_idx;
    logic [NUM_REQ-1:0] rr_grant, pick;
    logic               rr_valid, space_ok, lock_hold, xfer;
    logic [FIFO_CNT_W:0] occupancy;

    assign start_idx = IDX_W'(rr_next(32'(last_grant), NUM_REQ));

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .start (start_idx),
        .grant (rr_grant),
        .valid (rr_valid)
    );

    always_comb begin
        // the write already in flight is counted so the FIFO can never be overrun
        occupancy = {1'b0, fifo_counter} + {{FIFO_CNT_W{1'b0}}, wr_en};
        space_ok  = occupancy < DEPTH_LIM;
        lock_hold = (state == LOCK) && req_valid[last_grant]
                    && (burst_cnt < CNT_W'(BURST_LIMIT));
        pick      = lock_hold ? (NUM_REQ'(1) << last_grant) : rr_grant;
        xfer      = space_ok && !rst && (lock_hold || rr_valid);
        req_ready = xfer ? pick : '0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) win_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_next     = state;
        burst_cnt_next = burst_cnt;
`ifdef FIFO_ARB_BURST_EN
        if (xfer) begin
            // an expired or absent lock behaves as IDLE: the new winner opens a fresh burst
            state_next     = LOCK;
            burst_cnt_next = lock_hold ? burst_cnt + CNT_W'(1) : CNT_W'(1);
        end else if (state == LOCK && !lock_hold) begin
            state_next     = IDLE;
            burst_cnt_next = '0;
        end
`else
        state_next     = IDLE;
        burst_cnt_next = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en        <= 1'b0;
            buf_in       <= '0;
            grant_id     <= '0;
            overflow_err <= 1'b0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            state        <= IDLE;
            burst_cnt    <= '0;
        end else begin
            wr_en <= xfer;
            if (xfer) begin
                buf_in     <= req_data[win_idx*DATA_W +: DATA_W];
                grant_id   <= win_idx;
                last_grant <= win_idx;
            end
            if (wr_en && buf_full) overflow_err <= 1'b1;
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `FIFO_synchronous` write port among `NUM_REQ` producers. Each producer offers a word over a valid/ready handshake. The arbiter picks one winner per cycle when the FIFO has guaranteed space, registers the word, and drives `buf_in`/`wr_en` one cycle later. It sits directly in front of the FIFO and is the only driver of its write port.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 8: word width; matches FIFO `buf_in`.
- `FIFO_DEPTH`, default 64: FIFO capacity in words; must be at most 255.
- `BURST_LEN`, default 4: maximum consecutive grants to one requester; used only with `FIFO_ARB_BURST_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: single clock; everything samples on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: bit i means requester i offers `req_data` slice i.
- `req_data` in NUM_REQ*DATA_W: slice i is bits [i*DATA_W +: DATA_W].
- `req_ready` out NUM_REQ: one-hot or zero; combinational grant for the current cycle.
- `fifo_counter` in 8: FIFO occupancy.
- `buf_full` in 1: FIFO full flag; a sanity input only.
- `buf_in` out DATA_W: registered write data to the FIFO.
- `wr_en` out 1: registered write enable to the FIFO.
- `grant_id` out $clog2(NUM_REQ): requester index of the word on `buf_in`.
- `overflow_err` out 1: sticky error flag.

## Operation
- **Space check:** `space_ok = (fifo_counter + wr_en) < FIFO_DEPTH`, evaluated at 9-bit width. This counts the write already in flight.
- **Arbitration:** when `space_ok` is high and `rst` is low, `req_ready[i]` goes high for exactly one i. The winner is the first requester with `req_valid` set, scanning from `(last_grant+1) mod NUM_REQ` upward with wrap-around. At most one `req_ready` bit is high.
- **Transfer:** a transfer on requester i happens when `req_valid[i] & req_ready[i]` at a clock edge. On that edge:
  - `buf_in` <= slice i
  - `wr_en` <= 1
  - `grant_id` <= i
  - `last_grant` <= i
- **No transfer:** `wr_en` <= 0. `buf_in` and `grant_id` hold their values.
- **Producer rule:** once a producer raises `req_valid`, it must hold it and keep `req_data` stable until the transfer.
- **Simultaneous requests:** all valid → one grant per cycle in strict rotation 0,1,2,3,0,...
- **Single requester:** it is granted every cycle while `space_ok` is high.
- **Overflow error:** `overflow_err` is set when `wr_en` and `buf_full` are both high at an edge. It clears only on reset.
- **States:** `IDLE` and `LOCK`. Without the macro the FSM stays in `IDLE`.

## Timing
- **Reset values:**
  - `wr_en` = 0, `buf_in` = 0, `grant_id` = 0, `overflow_err` = 0
  - `last_grant` = NUM_REQ-1, so requester 0 has first priority
  - state = `IDLE`, burst count = 0
  - `req_ready` = 0 while `rst` is high
- **Latency:** handshake at edge k → `wr_en`=1 during cycle k+1 → the FIFO stores the word at edge k+1. Two edges from request to storage.
- **Throughput:** one word per cycle while `space_ok` holds.
- **Full boundary:**
  - `fifo_counter` = FIFO_DEPTH-1 with `wr_en`=1 → `req_ready` = 0 that cycle.
  - `fifo_counter` = FIFO_DEPTH with `wr_en`=0 → `req_ready` = 0.
- **Reset mid-operation:** a pending registered write is discarded; `wr_en` is 0 in the cycle after the reset edge. Producers must re-present their data.

## Configuration
- `FIFO_ARB_BURST_EN` defined: burst locking is enabled.
  - A grant from `IDLE` moves the FSM to `LOCK` and sets burst count to 1.
  - In `LOCK`, the locked requester wins regardless of rotation while its `req_valid` is high and burst count < BURST_LEN. Each grant increments the count.
  - The FSM returns to `IDLE` when the locked requester drops valid, or when burst count reaches BURST_LEN; rotation then resumes after it.
  - A cycle blocked by `space_ok` = 0 keeps the lock without counting.
- Undefined: every grant advances the rotation; behaves as BURST_LEN = 1.

## Structure
- Package `fifo_arb_pkg` contains:
  - `arb_state_t` enum (`IDLE`, `LOCK`)
  - localparam `FIFO_CNT_W` = 8
  - function `rr_next` for pointer wrap
- Sub-module `rr_priority_pick`: a combinational rotate-and-priority-encode. Inputs are the request vector and the start index; outputs are a one-hot grant and a valid flag. The arbiter owns all state.

## Test plan
- **Round robin:** NUM_REQ=4, all valid, data 8'hA0+i, FIFO empty → `buf_in` sequence A0, A1, A2, A3, A0 on consecutive cycles; `grant_id` 0,1,2,3,0.
- **Single requester:** only req 2 valid with 8'h55 for 3 words → `wr_en` high 3 consecutive cycles, starting the cycle after the first ready; `grant_id`=2.
- **Full boundary:** `fifo_counter`=63 with `wr_en`=1 → all `req_ready`=0. Next cycle `fifo_counter`=64 → still 0. Counter drops to 62 → a grant resumes.
- **Reset:** `rst` pulsed during a transfer → `wr_en`=0, `grant_id`=0, and requester 0 wins first after release.
- **Burst (`FIFO_ARB_BURST_EN`, BURST_LEN=4):** reqs 0 and 1 always valid → grant ids 0,0,0,0,1,1,1,1,0.
- **Overflow flag:** force `buf_full`=1 while `wr_en`=1 → `overflow_err`=1 and stays 1 until reset.
